// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR      = 32'h0;
  localparam int          PC_STEP        = 4;
  localparam int          PC_READ_OFFSET = 8;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between fetch_stage and imem.
interface fetch_stage_if #(
  parameter int DATA_W = 32
);
  logic              req;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] rdata;
  logic              valid;

  modport master (output req, addr, input rdata, valid);
  modport slave  (input req, addr, output rdata, valid);
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: clear beats hold, hold beats load, otherwise bubble.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              hold,
  input  logic              load,
  input  logic [DATA_W-1:0] load_instr,
  input  logic [DATA_W-1:0] load_pc,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] pc_plus8,
  output logic              valid
);

  logic [DATA_W-1:0] instr_reg;
  logic [DATA_W-1:0] pc_reg;
  logic [DATA_W-1:0] pc_plus8_reg;
  logic              valid_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      instr_reg    <= '0;
      pc_reg       <= '0;
      pc_plus8_reg <= '0;
      valid_reg    <= 1'b0;
    end else if (clear) begin
      instr_reg <= DATA_W'(NOP_INSTR);
      valid_reg <= 1'b0;
    end else if (hold) begin
      valid_reg <= valid_reg;
    end else if (load) begin
      instr_reg    <= load_instr;
      pc_reg       <= load_pc;
      pc_plus8_reg <= load_pc + DATA_W'(PC_READ_OFFSET);
      valid_reg    <= 1'b1;
    end else begin
      valid_reg <= 1'b0;
    end
  end

  assign instr    = instr_reg;
  assign pc       = pc_reg;
  assign pc_plus8 = pc_plus8_reg;
  assign valid    = valid_reg;

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC, single-outstanding imem requests, stall buffer and redirect.
// Optional FETCH_PERF_CNT_EN adds fetched/stall/discard counters.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_f,
  input  logic              flush_d,
  input  logic              pc_src,
  input  logic [DATA_W-1:0] branch_target,
  fetch_stage_if.master     imem,
  output logic [DATA_W-1:0] instr_d,
  output logic [DATA_W-1:0] pc_d,
  output logic [DATA_W-1:0] pc_plus8_d,
  output logic              valid_d
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall_cyc,
  output logic [31:0]       perf_discards
`endif
);

  fetch_state_t      state_reg, state_next;
  logic [DATA_W-1:0] pc_reg, pc_next;
  logic [DATA_W-1:0] redir_reg, redir_next;
  logic [DATA_W-1:0] buf_instr_reg, buf_instr_next;
  logic [DATA_W-1:0] buf_pc_reg, buf_pc_next;

  logic              clear;
  logic              load;
  logic              drop;
  logic [DATA_W-1:0] load_instr;
  logic [DATA_W-1:0] load_pc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      pc_reg        <= RESET_PC;
      redir_reg     <= '0;
      buf_instr_reg <= '0;
      buf_pc_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      redir_reg     <= redir_next;
      buf_instr_reg <= buf_instr_next;
      buf_pc_reg    <= buf_pc_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    redir_next     = redir_reg;
    buf_instr_next = buf_instr_reg;
    buf_pc_next    = buf_pc_reg;
    imem.req       = 1'b0;
    clear          = flush_d | pc_src;
    load           = 1'b0;
    drop           = 1'b0;
    load_instr     = imem.rdata;
    load_pc        = pc_reg;

    case (state_reg)
      IDLE: begin
        state_next = FETCH;
      end
      FETCH: begin
        imem.req = 1'b1;
        if (pc_src) begin
          // Without a response in hand the request is still in flight;
          // its reply must be swallowed before the new address is issued.
          if (imem.valid) begin
            pc_next = branch_target;
            drop    = 1'b1;
          end else begin
            redir_next = branch_target;
            state_next = DISCARD;
          end
        end else if (imem.valid) begin
          pc_next = pc_reg + DATA_W'(PC_STEP);
          if (stall_f) begin
            buf_instr_next = imem.rdata;
            buf_pc_next    = pc_reg;
            state_next     = HOLD;
          end else begin
            load = 1'b1;
          end
        end
      end
      HOLD: begin
        if (pc_src) begin
          pc_next    = branch_target;
          drop       = 1'b1;
          state_next = FETCH;
        end else if (!stall_f) begin
          load       = 1'b1;
          load_instr = buf_instr_reg;
          load_pc    = buf_pc_reg;
          state_next = FETCH;
        end
      end
      DISCARD: begin
        imem.req = 1'b1;
        if (imem.valid) begin
          drop       = 1'b1;
          pc_next    = pc_src ? branch_target : redir_reg;
          state_next = FETCH;
        end else if (pc_src) begin
          redir_next = branch_target;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign imem.addr = pc_reg;

  if_id_reg #(
    .DATA_W(DATA_W)
  ) u_if_id (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .hold      (stall_f),
    .load      (load),
    .load_instr(load_instr),
    .load_pc   (load_pc),
    .instr     (instr_d),
    .pc        (pc_d),
    .pc_plus8  (pc_plus8_d),
    .valid     (valid_d)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_reg, stall_cyc_reg, discards_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetched_reg   <= '0;
      stall_cyc_reg <= '0;
      discards_reg  <= '0;
    end else begin
      if (load && !clear && !stall_f) fetched_reg <= fetched_reg + 32'd1;
      if (stall_f && state_reg != IDLE) stall_cyc_reg <= stall_cyc_reg + 32'd1;
      if (drop) discards_reg <= discards_reg + 32'd1;
    end
  end

  assign perf_fetched   = fetched_reg;
  assign perf_stall_cyc = stall_cyc_reg;
  assign perf_discards  = discards_reg;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random stall/redirect traffic
// checked against an expected-PC stream model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_f = 1'b0;
  logic        flush_d = 1'b0;
  logic        pc_src = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] instr_d, pc_d, pc_plus8_d;
  logic        valid_d;
  logic [31:0] w_instr, w_pc, w_plus8;
  logic        w_valid;

  int          mode = 0;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;

  int          total = 0;
  int          bad = 0;
  int          ndeliv = 0;
  logic [31:0] exp_pc = '0;
  logic [31:0] prev_pc = '0, prev_instr = '0;
  logic        prev_valid = 1'b0;

  always #5 clk = ~clk;

  fetch_stage_if #(.DATA_W(32)) mif ();
  fetch_stage_if #(.DATA_W(32)) wif ();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_stall_cyc, perf_discards;
  logic [31:0] w_pf, w_ps, w_pd;
`endif

  fetch_stage #(.DATA_W(32), .RESET_PC(32'h0)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_f      (stall_f),
    .flush_d      (flush_d),
    .pc_src       (pc_src),
    .branch_target(branch_target),
    .imem         (mif),
    .instr_d      (instr_d),
    .pc_d         (pc_d),
    .pc_plus8_d   (pc_plus8_d),
    .valid_d      (valid_d)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_stall_cyc(perf_stall_cyc),
    .perf_discards (perf_discards)
`endif
  );

  fetch_stage #(.DATA_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk          (clk),
    .rst          (rst),
    .stall_f      (1'b0),
    .flush_d      (1'b0),
    .pc_src       (1'b0),
    .branch_target(32'h0),
    .imem         (wif),
    .instr_d      (w_instr),
    .pc_d         (w_pc),
    .pc_plus8_d   (w_plus8),
    .valid_d      (w_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched  (w_pf),
    .perf_stall_cyc(w_ps),
    .perf_discards (w_pd)
`endif
  );

  // Program image: word i holds i*16+1, i.e. byte address a holds a*4+1.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a << 2) + 32'd1;
  endfunction

  // mode 0: combinational ROM; mode 1: one-cycle latency, one outstanding.
  always_comb begin
    if (mode == 0) begin
      mif.valid = mif.req;
      mif.rdata = mem_word(mif.addr);
    end else begin
      mif.valid = pend;
      mif.rdata = mem_word(pend_addr);
    end
    wif.valid = wif.req;
    wif.rdata = mem_word(wif.addr);
  end

  always @(posedge clk) begin
    if (pend) pend <= 1'b0;
    else if (mif.req) begin
      pend      <= 1'b1;
      pend_addr <= mif.addr;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: apply inputs, sample 1ns after the edge, check against the stream model.
  task automatic cycle(input logic s, input logic f, input logic p, input logic [31:0] t);
    logic rst_e;
    stall_f = s; flush_d = f; pc_src = p; branch_target = t;
    rst_e = rst;
    @(posedge clk);
    #1;
    if (!rst_e) begin
      exp_pc = 32'h0;
    end else begin
      if (mode == 1 && pend) check("addr_stable", mif.addr, pend_addr);
      if (p) begin
        exp_pc = t;
        check("redir_valid", {31'b0, valid_d}, 32'd0);
        check("redir_instr", instr_d, 32'd0);
      end else if (f) begin
        check("flush_valid", {31'b0, valid_d}, 32'd0);
        check("flush_instr", instr_d, 32'd0);
      end else if (s) begin
        check("hold_pc", pc_d, prev_pc);
        check("hold_instr", instr_d, prev_instr);
        check("hold_valid", {31'b0, valid_d}, {31'b0, prev_valid});
      end else if (valid_d) begin
        check("deliv_pc", pc_d, exp_pc);
        check("deliv_instr", instr_d, mem_word(pc_d));
        check("deliv_plus8", pc_plus8_d, pc_d + 32'd8);
        exp_pc = pc_d + 32'd4;
        ndeliv++;
      end
    end
    prev_pc = pc_d; prev_instr = instr_d; prev_valid = valid_d;
  endtask

  task automatic do_reset(input int m);
    rst  = 1'b0;
    mode = m;
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 32'h0);
    check("rst_valid", {31'b0, valid_d}, 32'd0);
    check("rst_instr", instr_d, 32'd0);
    check("rst_pc", pc_d, 32'd0);
    check("rst_plus8", pc_plus8_d, 32'd0);
    check("rst_req", {31'b0, mif.req}, 32'd0);
    rst = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ew;
    logic [31:0] perf0;
    int          found;
    int          n0;
    logic        s, f, p;
    logic [31:0] t;

    perf0 = '0;

    // 1: in-order fetch from combinational ROM; wrap instance alongside
    do_reset(0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    check("t1_idle_valid", {31'b0, valid_d}, 32'd0);
    check("t1_req", {31'b0, mif.req}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 1'b0, 1'b0, 32'h0);
      check("t1_pc", pc_d, 32'(4 * k));
      check("t1_instr", instr_d, 32'(16 * k + 1));
      check("t1_plus8", pc_plus8_d, 32'(4 * k + 8));
      check("t1_valid", {31'b0, valid_d}, 32'd1);
      ew = 32'hFFFF_FFFC + 32'(4 * k);
      check("wrap_pc", w_pc, ew);
      check("wrap_plus8", w_plus8, ew + 32'd8);
      check("wrap_instr", w_instr, mem_word(ew));
    end

    // 2: stall while a response arrives for pc 8
    do_reset(0);
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 1'b0, 1'b0, 32'h0);
      check("s2_req", {31'b0, mif.req}, 32'd0);
      check("s2_hold_pc", pc_d, 32'd4);
    end
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    check("s2_rel_pc", pc_d, 32'd8);
    check("s2_rel_instr", instr_d, 32'd33);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    check("s2_next_pc", pc_d, 32'd12);

    // random traffic, both memory kinds
    for (int m = 0; m < 2; m++) begin
      do_reset(m);
      n0 = ndeliv;
      for (int i = 0; i < 400; i++) begin
        s = ($urandom % 100) < 30;
        p = (i > 2) && (($urandom % 100) < 8);
        f = p ? 1'($urandom % 2) : (s ? (($urandom % 4) == 0) : 1'b0);
        t = (($urandom % 16) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_0FFC);
        cycle(s, f, p, t);
      end
      check("rand_progress", {31'b0, (ndeliv - n0) > 40}, 32'd1);
    end

    // 3: redirect while a latency-1 request to 0x10 is in flight (mid-op reset first)
    do_reset(1);
    found = 0;
    for (int i = 0; i < 30 && found == 0; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 32'h0);
      if (valid_d && pc_d == 32'd12) found = 1;
    end
    check("s3_reach", 32'(found), 32'd1);
`ifdef FETCH_PERF_CNT_EN
    perf0 = perf_discards;
`endif
    cycle(1'b0, 1'b0, 1'b1, 32'h40);
    check("s3_req", {31'b0, mif.req}, 32'd1);
    check("s3_addr", mif.addr, 32'h10);
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 32'h0);
      if (valid_d) found = 1;
    end
    check("s3_load", 32'(found), 32'd1);
    check("s3_pc", pc_d, 32'h40);
    check("s3_instr", instr_d, mem_word(32'h40));
`ifdef FETCH_PERF_CNT_EN
    check("s3_perf_disc", perf_discards - perf0, 32'd1);
`endif

    // 4: redirect while holding a buffered instruction
    do_reset(0);
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check("s4_req", {31'b0, mif.req}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    perf0 = perf_discards;
`endif
    cycle(1'b0, 1'b0, 1'b1, 32'h80);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    check("s4_pc", pc_d, 32'h80);
    check("s4_valid", {31'b0, valid_d}, 32'd1);
`ifdef FETCH_PERF_CNT_EN
    check("s4_perf_disc", perf_discards - perf0, 32'd1);
`endif

    // 5: flush during stall leaves the PC stream intact
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    check("s5_pc", pc_d, 32'h84);
    check("s5_valid", {31'b0, valid_d}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the 32-bit core; directly upstream of the decode stage.
- Holds the PC and issues single-outstanding requests to instruction memory.
- Absorbs responses that arrive during a stall; redirects on taken branches.
- Presents instr_d, pc_d and pc_plus8_d to decode; pc_plus8_d is the R15 read value.

Parameters:
- DATA_W, 32, instruction/address width.
- RESET_PC, 32'h0000_0000, PC after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low (0 = reset).
- stall_f  in  1  hazard unit: hold IF/ID and PC.
- flush_d  in  1  hazard unit: bubble into IF/ID.
- pc_src  in  1  taken branch / PC write from a later stage.
- branch_target  in  DATA_W  redirect address, valid with pc_src.
- imem_req  out  1  fetch request.
- imem_addr  out  DATA_W  fetch address; stable while a request is outstanding.
- imem_rdata  in  DATA_W  instruction word; valid with imem_valid.
- imem_valid  in  1  one-cycle response pulse; may assert in the same cycle as imem_req (combinational ROM).
- instr_d  out  DATA_W  instruction to decode.
- pc_d  out  DATA_W  address of instr_d.
- pc_plus8_d  out  DATA_W  pc_d+8, feeds R15.
- valid_d  out  1  instr_d is a real instruction.

Behaviour:
- Reset (rst=0 at edge): state=IDLE; pc_f=RESET_PC; instr_d, pc_d, pc_plus8_d=0; valid_d=0; buffer cleared. imem_valid is ignored while in IDLE.
- FSM states: IDLE, FETCH, HOLD, DISCARD.
- IDLE:
  - imem_req=0.
  - Next state is FETCH unconditionally.
- FETCH:
  - imem_req=1, imem_addr=pc_f.
  - pc_src=1: drop any response this cycle; IF/ID cleared. If imem_valid=1: pc_f<=branch_target, stay FETCH. If imem_valid=0: redir_pc<=branch_target, go DISCARD.
  - imem_valid=1, stall_f=0: IF/ID<={rdata, pc_f, pc_f+8, 1}; pc_f<=pc_f+4; stay FETCH.
  - imem_valid=1, stall_f=1: buf<={rdata, pc_f}; pc_f<=pc_f+4; IF/ID holds; go HOLD.
  - imem_valid=0, stall_f=0: valid_d<=0 (bubble).
- HOLD:
  - imem_req=0.
  - pc_src=1: discard buf; pc_f<=branch_target; IF/ID cleared; go FETCH.
  - stall_f=0: IF/ID<=buf, valid_d<=1; go FETCH.
- DISCARD:
  - imem_req=1, imem_addr=pc_f (old address, unchanged).
  - A further pc_src overwrites redir_pc (latest wins).
  - On imem_valid: drop data; pc_f<=redir_pc; go FETCH.
  - IF/ID outputs valid_d=0 while in this state.
- IF/ID priority per edge: rst > pc_src/flush_d (clear to instr 0, valid 0) > stall_f (hold) > load > bubble. flush_d never affects pc_f or FSM.
- Throughput: combinational memory gives 1 instr/cycle; 1-cycle-latency memory gives 1 per 2 cycles.
- Arithmetic: PC adds are modulo 2^DATA_W. 32'hFFFF_FFFC+4 wraps to 0; pc_plus8_d wraps likewise.
- Mid-operation reset: any outstanding request is abandoned and any late imem_valid is ignored in IDLE.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_fetched, perf_stall_cyc, perf_discards (32 bits each, reset 0, wrap).
  - perf_fetched: +1 per IF/ID load with valid_d=1.
  - perf_stall_cyc: +1 per cycle with stall_f=1 and state≠IDLE.
  - perf_discards: +1 per response dropped in DISCARD or FETCH due to pc_src, and per buffer discarded in HOLD.
- Undefined: ports and logic are absent; the core behaviour is identical.

Decomposition:
- Package fetch_pkg holds:
  - fetch_state_t enum {IDLE, FETCH, HOLD, DISCARD}.
  - NOP_INSTR=32'h0.
  - PC_STEP=4.
  - PC_READ_OFFSET=8.
- Sub-module if_id_reg: load/hold/clear register for {instr, pc, pc+8, valid} with the priority above; the FSM and PC logic stay in fetch_stage.

Test Plan:
- Reset with combinational ROM where mem[i]=i*16+1; release rst → cycles 2..5 show pc_d=0,4,8,12, instr_d=1,17,33,49, pc_plus8_d=8,12,16,20, valid_d=1.
- stall_f=1 for 3 cycles while imem_valid pulses at pc 8 → HOLD; IF/ID holds pc_d=4; imem_req=0. On release, pc_d=8, instr_d=mem[2], with no duplicate and no skip.
- 1-cycle-latency memory, pc_src=1 with branch_target=0x40 while a request to 0x10 is outstanding → DISCARD; 0x10 data is never loaded; next load has pc_d=0x40.
- pc_src in HOLD with branch_target=0x80 → buffered instruction is discarded; next valid pc_d=0x80.
- flush_d=1 with stall_f=1 → valid_d=0 and instr_d=0 next cycle; pc_f is unchanged.
- RESET_PC=32'hFFFF_FFFC → pc_plus8_d=4 and next pc_d=0. With FETCH_PERF_CNT_EN, after the scenario 3 sequence perf_discards=1.
